// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding and the register-index defaults.
package hazard_pkg;

    localparam int unsigned ADDR_W_DEF = 5;

    // Index of the hard-wired zero register; writes to it never create a hazard.
    localparam int unsigned REG_X0 = 0;

    typedef enum logic [1:0] {
        StIdle,
        StLdStall,
        StMdBusy
    } hazard_state_e;

endpackage

// File: rtl/hazard_src_match.sv
// Compares the EX destination register against every used ID source operand.
// any_match is high when at least one live source reads the register EX will write.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned NUM_SRC = 2
) (
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [ADDR_W-1:0]         ex_rd,
    output logic                      any_match
);

    logic               rd_live;
    logic [NUM_SRC-1:0] src_match;

    assign rd_live = id_valid && (ex_rd != ADDR_W'(REG_X0));

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_match[i] = rd_live && id_rs_used[i]
                              && (id_rs[i*ADDR_W +: ADDR_W] == ex_rd);
    end

    assign any_match = |src_match;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller between IF/ID and ID/EX: load-use bubbles, mul/div front-end
// stall, redirect flush, and a saturating count of cycles with the PC frozen.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned MD_LAT       = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic                      ex_valid,
    input  logic [ADDR_W-1:0]         ex_rd,
    input  logic                      ex_regwrite,
    input  logic                      ex_memread,
    input  logic                      ex_is_md,
    input  logic                      ex_redirect,
    output logic                      pc_write,
    output logic                      ifid_write,
    output logic                      idex_bubble,
    output logic                      ifid_flush,
    output logic                      ex_hold,
    output logic                      md_busy,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int unsigned RemMax = (LOAD_BUBBLES > MD_LAT) ? LOAD_BUBBLES : MD_LAT;
    localparam int unsigned RemW   = $clog2(RemMax);

    localparam logic [RemW-1:0] LdRemInit = RemW'(LOAD_BUBBLES - 1);
    localparam logic [RemW-1:0] MdRemInit = RemW'(MD_LAT - 2);

    hazard_state_e     state_q, state_d;
    logic [RemW-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              any_match;
    logic              load_use;
    logic              md_start;

    hazard_src_match #(
        .ADDR_W  (ADDR_W),
        .NUM_SRC (NUM_SRC)
    ) u_src_match (
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .ex_rd      (ex_rd),
        .any_match  (any_match)
    );

    assign load_use = ex_valid && ex_memread && ex_regwrite && any_match;
    assign md_start = ex_valid && ex_is_md;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        ex_hold     = 1'b0;
        md_busy     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Redirect squashes the ID instruction, so a load-use on it is moot.
                if (ex_redirect) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        state_d = StLdStall;
                        rem_d   = LdRemInit;
                    end
                end else if (md_start) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    ex_hold    = 1'b1;
                    md_busy    = 1'b1;
                    state_d    = StMdBusy;
                    rem_d      = MdRemInit;
                end
            end

            StLdStall: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                rem_d       = rem_q - RemW'(1);
                if (rem_q == RemW'(1)) begin
                    state_d = StIdle;
                end
            end

            StMdBusy: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ex_hold    = 1'b1;
                md_busy    = 1'b1;
                if (rem_q == '0) begin
                    state_d = StIdle;
                end else begin
                    rem_d = rem_q - RemW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                rem_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
